debug_reg_dump: RTL and testbench
=================================

# debug_reg_dump

Debug read-out engine for the ID-stage register file. On a start pulse it walks the register file's debug read port from register 0 to register SIZE_REG-1. It latches each word and streams it byte-by-byte to the debug UART transmitter over a valid/ready handshake. It is the reader on the register file's debug read port and the producer feeding the TX byte channel.

## Interface
Parameters:
- NB_DATA, 32, register width in bits; must be a multiple of 8
- NB_REG, 5, register address width
- SIZE_REG, 32, number of registers dumped (addresses 0..SIZE_REG-1)
- NB_BYTE, 8, TX byte width

Ports:
- i_clk  in  1  single clock; everything updates on its rising edge
- i_reset  in  1  synchronous, active-high reset
- i_start  in  1  dump request; sampled only in IDLE
- o_address_read_debug  out  NB_REG  address driven to the register file debug read port
- i_data_read_debug  in  NB_DATA  combinational read data returned for o_address_read_debug
- o_tx_data  out  NB_BYTE  byte offered to the transmitter
- o_tx_valid  out  1  o_tx_data is valid
- i_tx_ready  in  1  transmitter accepts the byte this cycle
- o_busy  out  1  high in every state except IDLE
- o_done  out  1  one-cycle pulse when the final byte has been accepted

## Operation
- State machine IDLE -> LOAD -> SEND -> (LOAD | DONE) -> IDLE.
- IDLE:
  - o_tx_valid=0, o_busy=0.
  - On i_start=1: address counter <= 0, go to LOAD.
- LOAD (1 cycle):
  - The address has been stable since the previous edge.
  - Capture i_data_read_debug into the shift register, byte index <= 0, go to SEND.
- SEND:
  - o_tx_valid=1; o_tx_data = shift register bits [7:0], so bytes go out little-endian, byte 0 first.
  - Handshake occurs on an edge where o_tx_valid & i_tx_ready are both 1. On handshake, shift right by 8 and increment the byte index.
  - After byte NB_DATA/8-1 is accepted:
    - If address == SIZE_REG-1, go to DONE.
    - Otherwise, address+1 and go to LOAD.
  - While i_tx_ready=0, o_tx_data and o_tx_valid hold stable; valid never drops before acceptance.
- DONE (1 cycle): o_done=1, o_busy=1, then IDLE.
- i_start while busy is ignored and not queued. i_start held high in IDLE launches one dump per return to IDLE.
- Each word is a snapshot taken in its LOAD cycle. Pipeline writes to a register before its LOAD cycle are reflected; writes after it are not.
- The address counter does not wrap: it stops at SIZE_REG-1. The byte index wraps modulo NB_DATA/8.
- Reset in any state, mid-byte included:
  - Next state IDLE; the partial dump is abandoned and no resume occurs.
  - Outputs return to their reset values.

## Timing
- Reset values:
  - o_address_read_debug=0, o_tx_data=0, o_tx_valid=0
  - o_busy=0, o_done=0; internal shift register and byte index 0
- All outputs are registered. There is no combinational path from i_tx_ready to any output.
- Start sampled at edge E0:
  - LOAD during E0..E1; o_tx_valid rises after E1.
- With i_tx_ready tied high:
  - Each register costs 5 cycles (1 LOAD + 4 SEND).
  - The last handshake occurs at E160; o_done is high for E160..E161; o_busy falls after E161.
- Backpressure of N cycles on any byte adds exactly N cycles.
- A new i_start is accepted at earliest in the IDLE cycle following E161.

## Test plan
- Reset: assert i_reset for 2 cycles mid-idle -> every output 0; no o_tx_valid ever without i_start.
- Full dump, ready high, register file at its power-up contents (reg i holds i):
  - 128 bytes, ordered i,00,00,00 for i=0..31.
  - o_done pulses exactly once, 160 cycles after start.
  - o_busy is high throughout.
- Backpressure: drop i_tx_ready for 3 cycles on reg 2 byte 0 -> o_tx_data holds 02 with valid high for all 3 cycles; no byte lost or duplicated; o_done at cycle 163.
- Snapshot: write reg 5 = 0xDEADBEEF before its LOAD -> reg 5 bytes are EF BE AD DE. Write reg 3 = 0xFFFFFFFF after its LOAD -> reg 3 bytes are 03 00 00 00.
- Start while busy: pulse i_start during reg 10 -> ignored; exactly 128 bytes and one o_done.
- Reset mid-dump: assert i_reset during reg 7 byte 2 with ready low:
  - Next cycle o_tx_valid=0, o_busy=0, address 0.
  - A fresh i_start restarts from reg 0 byte 0.

Source files
------------

// File: rtl/debug_reg_dump.sv
// Walks the register file debug read port and streams every word to the UART TX channel, LSB byte first.
// Each register costs one LOAD cycle plus one cycle per accepted byte; a stalled byte holds data/valid until accepted.
module debug_reg_dump #(
   parameter int NB_DATA  = 32,
   parameter int NB_REG   = 5,
   parameter int SIZE_REG = 32,
   parameter int NB_BYTE  = 8
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_start,
   output logic [NB_REG-1:0]  o_address_read_debug,
   input  logic [NB_DATA-1:0] i_data_read_debug,
   output logic [NB_BYTE-1:0] o_tx_data,
   output logic               o_tx_valid,
   input  logic               i_tx_ready,
   output logic               o_busy,
   output logic               o_done
);

   localparam int N_BYTES = NB_DATA / NB_BYTE;
   localparam int NB_IDX  = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
   localparam logic [NB_REG-1:0] LAST_ADDR = NB_REG'(SIZE_REG - 1);
   localparam logic [NB_IDX-1:0] LAST_BYTE = NB_IDX'(N_BYTES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      SEND = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t             state;
   logic [NB_DATA-1:0] shift_reg;
   logic [NB_IDX-1:0]  byte_idx;

   // The outgoing byte is the low end of the shift register, so it is registered by construction.
   assign o_tx_data = shift_reg[NB_BYTE-1:0];

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state                <= IDLE;
         shift_reg            <= '0;
         byte_idx             <= '0;
         o_address_read_debug <= '0;
         o_tx_valid           <= 1'b0;
         o_busy               <= 1'b0;
         o_done               <= 1'b0;
      end else begin
         o_done <= 1'b0;
         case (state)
            IDLE: begin
               if (i_start) begin
                  o_address_read_debug <= '0;
                  o_busy               <= 1'b1;
                  state                <= LOAD;
               end
            end
            LOAD: begin
               shift_reg  <= i_data_read_debug;
               byte_idx   <= '0;
               o_tx_valid <= 1'b1;
               state      <= SEND;
            end
            SEND: begin
               if (o_tx_valid && i_tx_ready) begin
                  shift_reg <= shift_reg >> NB_BYTE;
                  if (byte_idx == LAST_BYTE) begin
                     byte_idx   <= '0;
                     o_tx_valid <= 1'b0;
                     if (o_address_read_debug == LAST_ADDR) begin
                        o_done <= 1'b1;
                        state  <= DONE;
                     end else begin
                        o_address_read_debug <= o_address_read_debug + 1'b1;
                        state                <= LOAD;
                     end
                  end else begin
                     byte_idx <= byte_idx + 1'b1;
                  end
               end
            end
            DONE: begin
               o_busy <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_debug_reg_dump.sv
// Bench for debug_reg_dump: directed vector table, reset corner cases and randomized backpressure/snapshot runs.
module tb_debug_reg_dump;

   logic        i_clk = 1'b0;
   logic        i_reset;
   logic        i_start;
   logic [4:0]  addr;
   logic [31:0] rdata;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        busy;
   logic        done;

   always #5 i_clk = ~i_clk;

   debug_reg_dump #(.NB_DATA(32), .NB_REG(5), .SIZE_REG(32), .NB_BYTE(8)) dut (
      .i_clk               (i_clk),
      .i_reset             (i_reset),
      .i_start             (i_start),
      .o_address_read_debug(addr),
      .i_data_read_debug   (rdata),
      .o_tx_data           (tx_data),
      .o_tx_valid          (tx_valid),
      .i_tx_ready          (tx_ready),
      .o_busy              (busy),
      .o_done              (done)
   );

   // Register file model with a combinational debug read port
   logic [31:0] rf [32];
   assign rdata = rf[addr];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Per-run scenario
   bit          ready_pat [1024];
   logic [31:0] init_rf   [32];
   int          wr_reg    [2];
   int          wr_cyc    [2];
   logic [31:0] wr_val    [2];
   int          start_pulse;

   logic [7:0] exp_b[$];
   int         exp_c[$];
   int         exp_done;
   logic [7:0] got_b[$];
   int         got_c[$];

   // Reference: each register costs one load cycle, then each byte waits for a ready cycle.
   // A write issued in cycle w is visible to a load happening in cycle L when w <= L.
   function automatic void build_model();
      int t = 0;
      logic [31:0] word;
      exp_b.delete();
      exp_c.delete();
      for (int r = 0; r < 32; r++) begin
         word = init_rf[r];
         for (int w = 0; w < 2; w++)
            if (wr_reg[w] == r && wr_cyc[w] <= t) word = wr_val[w];
         t++;
         for (int b = 0; b < 4; b++) begin
            while (t < 1000 && !ready_pat[t]) t++;
            exp_b.push_back(word[8*b +: 8]);
            exp_c.push_back(t);
            t++;
         end
      end
      exp_done = t;
   endfunction

   function automatic logic [31:0] got_word(input int r);
      if (4*r + 3 < got_b.size())
         return {got_b[4*r+3], got_b[4*r+2], got_b[4*r+1], got_b[4*r]};
      return 32'hxxxxxxxx;
   endfunction

   task automatic set_default();
      for (int i = 0; i < 32; i++) init_rf[i] = 32'(i);
      for (int k = 0; k < 1024; k++) ready_pat[k] = 1'b1;
      for (int w = 0; w < 2; w++) begin
         wr_reg[w] = -1;
         wr_cyc[w] = 0;
         wr_val[w] = '0;
      end
      start_pulse = -1;
   endtask

   task automatic run_dump(input string tag);
      int   done_cnt = 0;
      int   done_at  = -1;
      int   busy_err = 0;
      int   hold_err = 0;
      int   byte_err = 0;
      bit   prev_stall = 1'b0;
      logic [7:0] prev_data = '0;
      int   n;
      build_model();
      for (int i = 0; i < 32; i++) rf[i] = init_rf[i];
      got_b.delete();
      got_c.delete();
      @(negedge i_clk);
      i_start  = 1'b1;
      tx_ready = 1'b1;
      for (int k = 0; k <= exp_done + 2 && k < 1100; k++) begin
         @(negedge i_clk);
         i_start = (k == start_pulse);
         if (done === 1'b1) begin
            done_cnt++;
            done_at = k;
         end
         if (busy !== (k <= exp_done)) busy_err++;
         if (prev_stall && (tx_valid !== 1'b1 || tx_data !== prev_data)) hold_err++;
         for (int w = 0; w < 2; w++)
            if (wr_reg[w] >= 0 && wr_cyc[w] == k) rf[wr_reg[w]] = wr_val[w];
         tx_ready = (k < 1024) ? ready_pat[k] : 1'b1;
         if (tx_valid === 1'b1 && tx_ready) begin
            got_b.push_back(tx_data);
            got_c.push_back(k);
         end
         prev_stall = (tx_valid === 1'b1) && !tx_ready;
         prev_data  = tx_data;
      end
      i_start  = 1'b0;
      tx_ready = 1'b1;
      n = (got_b.size() < exp_b.size()) ? got_b.size() : exp_b.size();
      for (int i = 0; i < n; i++)
         if (got_b[i] !== exp_b[i] || got_c[i] != exp_c[i]) byte_err++;
      check({tag, "_nbytes"},    64'(got_b.size()), 64'(exp_b.size()));
      check({tag, "_stream"},    64'(byte_err), 64'd0);
      check({tag, "_done_count"}, 64'(done_cnt), 64'd1);
      check({tag, "_done_cycle"}, 64'(done_at), 64'(exp_done));
      check({tag, "_busy"},      64'(busy_err), 64'd0);
      check({tag, "_hold"},      64'(hold_err), 64'd0);
   endtask

   typedef struct {
      string       name;
      int          stall_at;
      int          stall_len;
      int          w0_reg;
      int          w0_cyc;
      logic [31:0] w0_val;
      int          w1_reg;
      int          w1_cyc;
      logic [31:0] w1_val;
      int          sp;
      int          chk_reg;
      logic [31:0] chk_word;
      int          chk2_reg;
      logic [31:0] chk2_word;
      int          exp_done_c;
   } vec_t;

   vec_t vecs[4];

   initial begin
      int valid_seen;
      vecs[0] = '{"plain",      -1, 0, -1, 0, 32'h0,        -1, 0, 32'h0,        -1, 31, 32'd31,       0, 32'd0,  160};
      vecs[1] = '{"backpress",  11, 3, -1, 0, 32'h0,        -1, 0, 32'h0,        -1,  2, 32'd2,        3, 32'd3,  163};
      vecs[2] = '{"snapshot",   -1, 0,  5, 10, 32'hDEADBEEF, 3, 20, 32'hFFFFFFFF, -1,  5, 32'hDEADBEEF, 3, 32'd3,  160};
      vecs[3] = '{"start_busy", -1, 0, -1, 0, 32'h0,        -1, 0, 32'h0,        52, 10, 32'd10,      11, 32'd11, 160};

      set_default();
      for (int i = 0; i < 32; i++) rf[i] = 32'(i);
      i_reset  = 1'b1;
      i_start  = 1'b0;
      tx_ready = 1'b1;
      repeat (2) @(posedge i_clk);
      @(negedge i_clk);
      i_reset = 1'b0;
      repeat (5) @(negedge i_clk);
      i_reset = 1'b1;
      repeat (2) @(negedge i_clk);
      check("rst_valid", 64'(tx_valid), 64'd0);
      check("rst_busy",  64'(busy),     64'd0);
      check("rst_done",  64'(done),     64'd0);
      check("rst_addr",  64'(addr),     64'd0);
      check("rst_data",  64'(tx_data),  64'd0);
      i_reset    = 1'b0;
      valid_seen = 0;
      repeat (20) begin
         @(negedge i_clk);
         if (tx_valid !== 1'b0 || busy !== 1'b0) valid_seen++;
      end
      check("idle_quiet", 64'(valid_seen), 64'd0);

      foreach (vecs[v]) begin
         set_default();
         for (int k = 0; k < vecs[v].stall_len; k++) ready_pat[vecs[v].stall_at + k] = 1'b0;
         wr_reg[0] = vecs[v].w0_reg; wr_cyc[0] = vecs[v].w0_cyc; wr_val[0] = vecs[v].w0_val;
         wr_reg[1] = vecs[v].w1_reg; wr_cyc[1] = vecs[v].w1_cyc; wr_val[1] = vecs[v].w1_val;
         start_pulse = vecs[v].sp;
         run_dump(vecs[v].name);
         check({vecs[v].name, "_spec_done"}, 64'(exp_done), 64'(vecs[v].exp_done_c));
         check({vecs[v].name, "_word_a"}, 64'(got_word(vecs[v].chk_reg)),  64'(vecs[v].chk_word));
         check({vecs[v].name, "_word_b"}, 64'(got_word(vecs[v].chk2_reg)), 64'(vecs[v].chk2_word));
      end

      // Reset while reg 7 byte 2 is stalled, then a fresh dump must start from reg 0 byte 0
      set_default();
      for (int i = 0; i < 32; i++) rf[i] = 32'(i);
      @(negedge i_clk);
      i_start = 1'b1;
      for (int k = 0; k <= 38; k++) begin
         @(negedge i_clk);
         i_start  = 1'b0;
         tx_ready = (k < 38);
      end
      @(negedge i_clk);
      check("midrst_pre_valid", 64'(tx_valid), 64'd1);
      check("midrst_pre_addr",  64'(addr),     64'd7);
      i_reset = 1'b1;
      @(negedge i_clk);
      check("midrst_valid", 64'(tx_valid), 64'd0);
      check("midrst_busy",  64'(busy),     64'd0);
      check("midrst_addr",  64'(addr),     64'd0);
      check("midrst_done",  64'(done),     64'd0);
      i_reset  = 1'b0;
      tx_ready = 1'b1;
      run_dump("after_rst");

      for (int r = 0; r < 3; r++) begin
         set_default();
         for (int i = 0; i < 32; i++) init_rf[i] = $urandom;
         for (int k = 0; k < 1024; k++) ready_pat[k] = ($urandom_range(0, 3) != 0);
         wr_reg[0]   = $urandom_range(0, 31);
         wr_cyc[0]   = $urandom_range(0, 150);
         wr_val[0]   = $urandom;
         start_pulse = $urandom_range(5, 150);
         run_dump($sformatf("rand%0d", r));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
